// File: rtl/snitch_icache_refill.sv
// rtl/snitch_icache_refill.sv - icache line refill engine with in-order pending-ID FIFO
module snitch_icache_refill #(
  parameter int FETCH_AW        = 48,
  parameter int LINE_WIDTH      = 256,
  parameter int BEAT_WIDTH      = 64,
  parameter int PENDING_IW      = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [FETCH_AW-1:0]   in_req_addr_i,
  input  logic [PENDING_IW-1:0] in_req_id_i,
  input  logic                  in_req_valid_i,
  output logic                  in_req_ready_o,
  output logic [LINE_WIDTH-1:0] in_rsp_data_o,
  output logic                  in_rsp_error_o,
  output logic [PENDING_IW-1:0] in_rsp_id_o,
  output logic                  in_rsp_valid_o,
  input  logic                  in_rsp_ready_i,
  output logic [FETCH_AW-1:0]   mem_req_addr_o,
  output logic [7:0]            mem_req_len_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  input  logic [BEAT_WIDTH-1:0] mem_rsp_data_i,
  input  logic                  mem_rsp_error_i,
  input  logic                  mem_rsp_last_i,
  input  logic                  mem_rsp_valid_i,
  output logic                  mem_rsp_ready_o
);

  localparam int BEATS      = LINE_WIDTH / BEAT_WIDTH;
  localparam int LINE_ALIGN = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int PTR_W      = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OCC_W      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [FETCH_AW-1:0] ALIGN_MASK =
      ~((FETCH_AW'(1) << LINE_ALIGN) - FETCH_AW'(1));

  typedef enum logic {ASSEMBLE, HOLD} state_e;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    err_q;
  logic [LINE_WIDTH-1:0]   line_q;

  logic [PENDING_IW-1:0]   id_mem_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0]        occ_q, occ_d;

  logic full, empty, push, pop, hold, beat_fire, cnt_last;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (occ_q == OCC_W'(MAX_OUTSTANDING));
  assign empty = (occ_q == '0);
  assign hold  = (state_q == HOLD);

  // Request path is a pure pass-through; the ID is captured on the handshake.
  assign mem_req_valid_o = in_req_valid_i & ~full;
  assign in_req_ready_o  = mem_req_ready_i & ~full;
  assign mem_req_addr_o  = in_req_addr_i & ALIGN_MASK;
  assign mem_req_len_o   = 8'(BEATS - 1);

  assign push = in_req_valid_i & in_req_ready_o;
  assign pop  = hold & in_rsp_ready_i;

  // Beats are only taken when there is an outstanding ID to attribute them to.
  assign mem_rsp_ready_o = ~hold & ~empty;
  assign beat_fire       = mem_rsp_ready_o & mem_rsp_valid_i;
  assign cnt_last        = (cnt_q == CNT_W'(BEATS - 1));

  assign in_rsp_valid_o = hold;
  assign in_rsp_id_o    = hold ? id_mem_q[rd_ptr_q] : '0;
  assign in_rsp_error_o = hold & err_q;
  assign in_rsp_data_o  = line_q;

  // Next-state for the ID FIFO pointers and occupancy.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
  end

  // ID FIFO control state.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // ID FIFO storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) id_mem_q[wr_ptr_q] <= in_req_id_i;
  end

  // Response FSM: assemble beats into the line, then hold it until consumed.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ASSEMBLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      line_q  <= '0;
    end else begin
      case (state_q)
        ASSEMBLE: begin
          if (beat_fire) begin
            for (int k = 0; k < BEATS; k++) begin
              if (cnt_q == CNT_W'(k)) line_q[k*BEAT_WIDTH +: BEAT_WIDTH] <= mem_rsp_data_i;
            end
            // A last flag that disagrees with the beat count flags the line.
            err_q <= err_q | mem_rsp_error_i | (cnt_last ^ mem_rsp_last_i);
            if (cnt_last || mem_rsp_last_i) begin
              cnt_q   <= '0;
              state_q <= HOLD;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          if (in_rsp_ready_i) begin
            line_q  <= '0;
            err_q   <= 1'b0;
            state_q <= ASSEMBLE;
          end
        end
        default: state_q <= ASSEMBLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snitch_icache_refill.sv
// tb/tb_snitch_icache_refill.sv - directed self-checking bench for snitch_icache_refill
module tb_snitch_icache_refill;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic [47:0]  in_req_addr_i;
  logic [1:0]   in_req_id_i;
  logic         in_req_valid_i;
  logic         in_req_ready_o;
  logic [255:0] in_rsp_data_o;
  logic         in_rsp_error_o;
  logic [1:0]   in_rsp_id_o;
  logic         in_rsp_valid_o;
  logic         in_rsp_ready_i;
  logic [47:0]  mem_req_addr_o;
  logic [7:0]   mem_req_len_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [63:0]  mem_rsp_data_i;
  logic         mem_rsp_error_i;
  logic         mem_rsp_last_i;
  logic         mem_rsp_valid_i;
  logic         mem_rsp_ready_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  snitch_icache_refill dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .in_req_addr_i   (in_req_addr_i),
    .in_req_id_i     (in_req_id_i),
    .in_req_valid_i  (in_req_valid_i),
    .in_req_ready_o  (in_req_ready_o),
    .in_rsp_data_o   (in_rsp_data_o),
    .in_rsp_error_o  (in_rsp_error_o),
    .in_rsp_id_o     (in_rsp_id_o),
    .in_rsp_valid_o  (in_rsp_valid_o),
    .in_rsp_ready_i  (in_rsp_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_len_o   (mem_req_len_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_rsp_data_i  (mem_rsp_data_i),
    .mem_rsp_error_i (mem_rsp_error_i),
    .mem_rsp_last_i  (mem_rsp_last_i),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_ready_o (mem_rsp_ready_o)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [63:0] b0, input logic [63:0] b1,
                                           input logic [63:0] b2, input logic [63:0] b3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic push_req(input logic [47:0] addr, input logic [1:0] id);
    in_req_addr_i  = addr;
    in_req_id_i    = id;
    in_req_valid_i = 1'b1;
    @(negedge clk_i);
    check("req_ready", in_req_ready_o, 1'b1);
    @(posedge clk_i); #1;
    in_req_valid_i = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic e, input logic l);
    mem_rsp_data_i  = d;
    mem_rsp_error_i = e;
    mem_rsp_last_i  = l;
    mem_rsp_valid_i = 1'b1;
    @(negedge clk_i);
    check("beat_ready", mem_rsp_ready_o, 1'b1);
    @(posedge clk_i); #1;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_error_i = 1'b0;
    mem_rsp_last_i  = 1'b0;
  endtask

  task automatic send_full(input logic [63:0] base);
    for (int j = 0; j < 4; j++) send_beat(base + 64'(j), 1'b0, j == 3);
  endtask

  task automatic expect_rsp(input logic [1:0] id, input logic [255:0] data, input logic err);
    @(negedge clk_i);
    check("rsp_valid", in_rsp_valid_o, 1'b1);
    check("rsp_id", in_rsp_id_o, id);
    check("rsp_data", in_rsp_data_o, data);
    check("rsp_error", in_rsp_error_o, err);
    check("hold_beat_ready", mem_rsp_ready_o, 1'b0);
    in_rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    in_rsp_ready_i = 1'b0;
    @(negedge clk_i);
    check("rsp_valid_after_pop", in_rsp_valid_o, 1'b0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [255:0] line;
    logic [1:0]   order [4];
    rst_ni          = 1'b0;
    in_req_addr_i   = 48'h0;
    in_req_id_i     = 2'd0;
    in_req_valid_i  = 1'b1;
    in_rsp_ready_i  = 1'b0;
    mem_req_ready_i = 1'b1;
    mem_rsp_data_i  = 64'h0;
    mem_rsp_error_i = 1'b0;
    mem_rsp_last_i  = 1'b0;
    mem_rsp_valid_i = 1'b0;

    // Reset values
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("rst_rsp_valid", in_rsp_valid_o, 1'b0);
    check("rst_rsp_error", in_rsp_error_o, 1'b0);
    check("rst_rsp_data", in_rsp_data_o, 256'h0);
    check("rst_rsp_id", in_rsp_id_o, 2'd0);
    check("rst_beat_ready", mem_rsp_ready_o, 1'b0);
    check("rst_req_ready", in_req_ready_o, 1'b1);
    check("rst_mem_req_valid", mem_req_valid_o, 1'b1);
    check("rst_len", mem_req_len_o, 8'd3);
    @(posedge clk_i); #1;
    rst_ni         = 1'b1;
    in_req_valid_i = 1'b0;
    @(posedge clk_i); #1;

    // Single refill
    in_req_addr_i  = 48'h0000_1234_5678;
    in_req_id_i    = 2'd2;
    in_req_valid_i = 1'b1;
    @(negedge clk_i);
    check("single_addr", mem_req_addr_o, 48'h0000_1234_5660);
    check("single_len", mem_req_len_o, 8'd3);
    check("single_mem_valid", mem_req_valid_o, 1'b1);
    check("single_req_ready", in_req_ready_o, 1'b1);
    @(posedge clk_i); #1;
    in_req_valid_i = 1'b0;
    send_beat(64'hA, 1'b0, 1'b0);
    send_beat(64'hB, 1'b0, 1'b0);
    send_beat(64'hC, 1'b0, 1'b0);
    send_beat(64'hD, 1'b0, 1'b1);
    expect_rsp(2'd2, mk_line(64'hA, 64'hB, 64'hC, 64'hD), 1'b0);

    // Back-pressure, ordering, and the full-FIFO push/pop edge
    for (int i = 0; i < 4; i++) push_req(48'h1000 + 48'(i * 32), 2'(i));
    in_req_valid_i = 1'b1;
    in_req_id_i    = 2'd3;
    @(negedge clk_i);
    check("full_req_ready", in_req_ready_o, 1'b0);
    check("full_mem_valid", mem_req_valid_o, 1'b0);
    @(posedge clk_i); #1;
    in_req_valid_i = 1'b0;
    send_full(64'h100);
    line = mk_line(64'h100, 64'h101, 64'h102, 64'h103);
    mem_rsp_data_i  = 64'hDEAD;
    mem_rsp_last_i  = 1'b1;
    mem_rsp_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      check("bp_valid", in_rsp_valid_o, 1'b1);
      check("bp_id", in_rsp_id_o, 2'd0);
      check("bp_data", in_rsp_data_o, line);
      check("bp_beat_ready", mem_rsp_ready_o, 1'b0);
      @(posedge clk_i); #1;
    end
    mem_rsp_valid_i = 1'b0;
    mem_rsp_last_i  = 1'b0;
    in_rsp_ready_i  = 1'b1;
    in_req_valid_i  = 1'b1;
    in_req_id_i     = 2'd0;
    @(negedge clk_i);
    check("edge_req_ready_pop_cycle", in_req_ready_o, 1'b0);
    check("edge_rsp_valid", in_rsp_valid_o, 1'b1);
    @(posedge clk_i); #1;
    in_rsp_ready_i = 1'b0;
    @(negedge clk_i);
    check("edge_req_ready_next", in_req_ready_o, 1'b1);
    check("edge_beat_ready_next", mem_rsp_ready_o, 1'b1);
    check("edge_valid_next", in_rsp_valid_o, 1'b0);
    @(posedge clk_i); #1;
    in_req_valid_i = 1'b0;
    order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd3; order[3] = 2'd0;
    for (int k = 0; k < 4; k++) begin
      send_full(64'h200 + 64'(k * 16));
      expect_rsp(order[k], mk_line(64'h200 + 64'(k * 16), 64'h201 + 64'(k * 16),
                                   64'h202 + 64'(k * 16), 64'h203 + 64'(k * 16)), 1'b0);
    end
    @(negedge clk_i);
    check("drained_beat_ready", mem_rsp_ready_o, 1'b0);
    @(posedge clk_i); #1;

    // Beat error then a clean line
    push_req(48'h2000, 2'd1);
    push_req(48'h2020, 2'd2);
    send_beat(64'hA0, 1'b0, 1'b0);
    send_beat(64'hA1, 1'b1, 1'b0);
    send_beat(64'hA2, 1'b0, 1'b0);
    send_beat(64'hA3, 1'b0, 1'b1);
    expect_rsp(2'd1, mk_line(64'hA0, 64'hA1, 64'hA2, 64'hA3), 1'b1);
    send_full(64'hB0);
    expect_rsp(2'd2, mk_line(64'hB0, 64'hB1, 64'hB2, 64'hB3), 1'b0);

    // Length mismatch: early last, then missing last
    push_req(48'h3000, 2'd3);
    push_req(48'h3020, 2'd0);
    send_beat(64'hC0, 1'b0, 1'b0);
    send_beat(64'hC1, 1'b0, 1'b1);
    expect_rsp(2'd3, mk_line(64'hC0, 64'hC1, 64'h0, 64'h0), 1'b1);
    for (int j = 0; j < 4; j++) send_beat(64'hD0 + 64'(j), 1'b0, 1'b0);
    expect_rsp(2'd0, mk_line(64'hD0, 64'hD1, 64'hD2, 64'hD3), 1'b1);

    // Mid-burst reset
    push_req(48'h4000, 2'd1);
    send_beat(64'hE0, 1'b1, 1'b0);
    send_beat(64'hE1, 1'b0, 1'b0);
    rst_ni = 1'b0;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("mrst_rsp_valid", in_rsp_valid_o, 1'b0);
    check("mrst_beat_ready", mem_rsp_ready_o, 1'b0);
    check("mrst_data", in_rsp_data_o, 256'h0);
    @(posedge clk_i); #1;
    push_req(48'h5000, 2'd2);
    send_full(64'hF0);
    expect_rsp(2'd2, mk_line(64'hF0, 64'hF1, 64'hF2, 64'hF3), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/snitch_icache_refill.md
# snitch_icache_refill

Refill engine between the instruction-cache miss handler and the memory side. Accepts line-refill requests (line address plus pending-table ID) from the miss handler and issues one burst read per line. Assembles the returned narrow beats into a full cache line and returns line, error flag and pending ID to the miss handler's refill-response port. Memory returns bursts in request order; the block tracks outstanding IDs in an in-order FIFO.

## Interface
- FETCH_AW, 48: fetch address width.
- LINE_WIDTH, 256: cache line width in bits.
- BEAT_WIDTH, 64: memory data beat width. LINE_WIDTH must be an integer multiple of BEAT_WIDTH, with at least 1 beat.
- PENDING_IW, 2: pending-table ID width.
- MAX_OUTSTANDING, 4: ID FIFO depth, in the range 1..2^PENDING_IW.
- Derived: BEATS = LINE_WIDTH/BEAT_WIDTH; LINE_ALIGN = log2(LINE_WIDTH/8).

Ports (clock and reset first):
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low.
- in_req_addr_i  in  FETCH_AW  refill line address.
- in_req_id_i  in  PENDING_IW  pending-table ID.
- in_req_valid_i  in  1  request valid.
- in_req_ready_o  out  1  request accepted.
- in_rsp_data_o  out  LINE_WIDTH  assembled line.
- in_rsp_error_o  out  1  any beat errored, or a burst-length mismatch occurred.
- in_rsp_id_o  out  PENDING_IW  ID of the returned line.
- in_rsp_valid_o  out  1  line valid.
- in_rsp_ready_i  in  1  line consumed.
- mem_req_addr_o  out  FETCH_AW  line-aligned burst address.
- mem_req_len_o  out  8  BEATS-1 (constant).
- mem_req_valid_o  out  1  burst request valid.
- mem_req_ready_i  in  1  burst accepted.
- mem_rsp_data_i  in  BEAT_WIDTH  beat data.
- mem_rsp_error_i  in  1  beat error.
- mem_rsp_last_i  in  1  last beat of burst.
- mem_rsp_valid_i  in  1  beat valid.
- mem_rsp_ready_o  out  1  beat accepted.

## Operation
**Request path** (combinational pass-through, no buffering):
- mem_req_valid_o = in_req_valid_i & ~full.
- in_req_ready_o = mem_req_ready_i & ~full.
- mem_req_addr_o = in_req_addr_i with the low LINE_ALIGN bits cleared.
- On the handshake, in_req_id_i is pushed into the ID FIFO.
- `full` is registered FIFO state. A pop in the same cycle does not allow a push while full.

**Response path**, FSM {ASSEMBLE, HOLD}; reset state is ASSEMBLE.
- ASSEMBLE:
  - mem_rsp_ready_o = FIFO non-empty.
  - A beat arriving while the FIFO is empty is not accepted (illegal traffic; no state change).
  - Each accepted beat k (beat counter cnt, 0..BEATS-1) is written to line[k*BEAT_WIDTH +: BEAT_WIDTH] (little-endian beat order).
  - err_q |= mem_rsp_error_i.
  - Line completes on the accepted beat where cnt==BEATS-1 or mem_rsp_last_i=1.
  - If (cnt==BEATS-1) != mem_rsp_last_i on that beat, err_q is set.
  - On completion: cnt←0, go to HOLD.
- HOLD:
  - in_rsp_valid_o=1; in_rsp_id_o = FIFO head; in_rsp_error_o = err_q.
  - in_rsp_data_o = line register; bits not written in this burst read as 0.
  - mem_rsp_ready_o=0.
  - On in_rsp_ready_i: pop FIFO, clear the line register and err_q, go to ASSEMBLE.
- Outputs hold stable while in_rsp_valid_o=1 and in_rsp_ready_i=0.
- If a burst ends early (last before BEATS), the missing beats read 0 and the error flag is set. If a burst runs long, the beat with cnt==BEATS-1 closes the line, and the next beat is attributed to the next FIFO entry.

**Reset** (any time, including mid-burst): FIFO emptied, cnt=0, err_q=0, line register=0, state ASSEMBLE.

## Timing
- Output values in reset:
  - in_rsp_valid_o=0, in_rsp_error_o=0, in_rsp_data_o=0.
  - in_rsp_id_o=0, mem_rsp_ready_o=0.
  - in_req_ready_o and mem_req_valid_o follow their inputs (FIFO not full).
  - mem_req_len_o is constant.
- Request: zero-cycle pass-through; the FIFO push is visible the next cycle.
- Last beat accepted in cycle t → in_rsp_valid_o=1 in cycle t+1. Minimum line turnaround is BEATS+1 cycles per line at full beat rate.
- Handshake in HOLD in cycle t → mem_rsp_ready_o=1 in cycle t+1 (if the FIFO is still non-empty).
- Simultaneous push and pop on a non-full FIFO: both take effect; occupancy is unchanged.
- Up to MAX_OUTSTANDING bursts may be in flight; requests stall when full.

## Test plan
- **Single refill:** BEATS=4, addr 0x1234_5678, id 2, beats 0xA..0xD with last on beat 3 → mem_req_addr_o=0x1234_5660, len=3; one cycle after the last beat, in_rsp_data_o = {0xD,0xC,0xB,0xA} (beat 0 in LSBs), id 2, error 0.
- **Back-pressure and ordering:** push ids 0,1,2,3 with in_rsp_ready_i held at 0 → the 5th request is stalled (in_req_ready_o=0); the response returns id 0 held stable, and mem_rsp_ready_o=0 until the handshake; then ids 1,2,3 return in order.
- **Beat error:** mem_rsp_error_i=1 on beat 1 only → in_rsp_error_o=1, data still assembled; the next line returns with error 0.
- **Length mismatch:** last asserted on beat 1 → the line completes after 2 beats, upper two beats read 0, error 1. Second case: no last on beat 3 → error 1.
- **Full FIFO edge:** at FIFO full, issue a request in the same cycle as a response pop → request not accepted that cycle; accepted the next cycle.
- **Mid-burst reset:** assert rst_ni=0 after 2 beats → next cycle in_rsp_valid_o=0, mem_rsp_ready_o=0; a fresh request then returns a clean line with no stale data.
